fa_stim_checker: RTL and testbench
==================================

FA_STIM_CHECKER -- requirements
Module: fa_stim_checker

Interface
REQ-001 The block SHALL have parameter DWELL, default 6, meaning clock cycles each input vector is held before its outputs are sampled (legal 2..255).
REQ-002 The block SHALL have parameter NVEC, default 8, meaning the number of vectors applied, counted from 0 (legal 1..8).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a test run.
REQ-006 The block SHALL have port I0, output, 1, adder operand A driven to the device under test.
REQ-007 The block SHALL have port I1, output, 1, adder operand B.
REQ-008 The block SHALL have port I2, output, 1, adder carry-in.
REQ-009 The block SHALL have port sum, input, 1, sum returned by the device under test.
REQ-010 The block SHALL have port carry, input, 1, carry returned by the device under test.
REQ-011 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when a run completes.
REQ-013 The block SHALL have port pass, output, 1, high after a run with zero mismatches; held until the next start.
REQ-014 The block SHALL have port err_count, output, 4, the number of mismatching vectors in the last run.
REQ-015 The block SHALL have port fail_vec, output, 8, where bit k is set if vector k mismatched.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SAMPLE, NEXT and FINISH.
REQ-017 In IDLE, start=1 SHALL clear err_count, fail_vec, pass and the vector index, and enter DRIVE on the next edge.
REQ-018 In DRIVE, {I0,I1,I2} SHALL equal the 3-bit vector index (I0 is the MSB), held for exactly DWELL cycles via a dwell counter.
REQ-019 In SAMPLE (one cycle), the block SHALL compare sum against I0^I1^I2 and carry against the majority of (I0,I1,I2).
REQ-020 On a mismatch, err_count SHALL increment (saturating at 15) and fail_vec[index] SHALL be set.
REQ-021 In NEXT, if index==NVEC-1 the FSM SHALL go to FINISH; otherwise index SHALL increment and the FSM SHALL return to DRIVE.
REQ-022 FINISH SHALL last one cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-023 busy SHALL be high in DRIVE, SAMPLE, NEXT and FINISH, and low in IDLE.
REQ-024 start SHALL be ignored while busy.
REQ-025 Operands SHALL remain stable from the first DRIVE cycle through SAMPLE for each vector.
REQ-026 In IDLE, operands SHALL be held at 0.
REQ-027 The latency from start to done SHALL be exactly 1 + NVEC*(DWELL+2) cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, I0=I1=I2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0 and dwell counter=0.
REQ-029 A reset during a run SHALL abort the run without producing a done pulse.
REQ-030 After reset is released, the block SHALL wait for a fresh start.

Configuration
REQ-031 Macro FA_CHK_STOP_ON_FAIL_EN: when defined, the first mismatch SHALL send the FSM from SAMPLE directly to FINISH, with fail_vec holding only that vector.
REQ-032 When FA_CHK_STOP_ON_FAIL_EN is undefined, all NVEC vectors SHALL always be applied.

Structure
REQ-033 Package fa_chk_pkg SHALL hold the state enum, the DWELL/NVEC default constants, and a pure expected-result function returning {carry,sum} from three bits.
REQ-034 The golden model SHALL be one sub-module, fa_ref_model (combinational, 3 in / 2 out), instantiated once; no other sub-modules.

Verification
REQ-035 Scenario: ideal adder model, DWELL=6, start pulse -> done 65 cycles later, pass=1, err_count=0, fail_vec=8'h00.
REQ-036 Scenario: carry stuck at 0 -> err_count=4, fail_vec=8'b1110_1000 (vectors 3,5,6,7), pass=0.
REQ-037 Scenario: sum inverted, FA_CHK_STOP_ON_FAIL_EN defined -> done after vector 0, err_count=1, fail_vec=8'h01.
REQ-038 Scenario: rst_n low mid-run at vector 4 -> all outputs 0 asynchronously; no done pulse; a new start runs cleanly to pass=1.
REQ-039 Scenario: start re-pulsed while busy -> run unaffected; done fires once at cycle 65.
REQ-040 Scenario: NVEC=1 -> only {0,0,0} applied; done at cycle 9.

Source files
------------

// File: rtl/fa_chk_pkg.sv
// -----------------------------------------------------------------------------
// fa_chk_pkg
// Shared definitions for the full-adder stimulus checker:
//   state_t        - checker FSM states
//   DWELL_DEFAULT  - default cycles each vector is held before sampling
//   NVEC_DEFAULT   - default number of vectors applied per run
//   ERR_MAX        - saturation value of the mismatch counter
//   fa_expected()  - golden full-adder result, returned as {carry,sum}
// -----------------------------------------------------------------------------
package fa_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      NEXT,
      FINISH
   } state_t;

   localparam int DWELL_DEFAULT = 6;
   localparam int NVEC_DEFAULT  = 8;
   localparam logic [3:0] ERR_MAX = 4'd15;

   // Reference behaviour of a one-bit full adder: sum is the parity of the
   // three inputs, carry is their majority.
   function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
      logic s;
      logic c;
      s = a ^ b ^ cin;
      c = (a & b) | (a & cin) | (b & cin);
      return {c, s};
   endfunction

endpackage

// File: rtl/fa_ref_model.sv
// -----------------------------------------------------------------------------
// fa_ref_model
// Purely combinational golden full adder used by the checker to decide what
// the device under test should have returned for the current operands.
// Ports:
//   a, b, cin  (in)  - operands and carry-in currently driven to the DUT
//   sum, carry (out) - expected full-adder result
// -----------------------------------------------------------------------------
module fa_ref_model
   import fa_chk_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   always_comb begin
      {carry, sum} = fa_expected(a, b, cin);
   end

endmodule

// File: rtl/fa_stim_checker.sv
// -----------------------------------------------------------------------------
// fa_stim_checker
// Walks a one-bit full adder through the first NVEC input combinations, holds
// each vector for DWELL cycles, samples the adder's answer and compares it
// against fa_ref_model. Mismatching vectors are counted and flagged.
//
// Parameters:
//   DWELL - cycles each vector is held before sampling (2..255)
//   NVEC  - number of vectors applied, starting at 0 (1..8)
// Ports:
//   clk        (in)  - clock, rising edge
//   rst_n      (in)  - asynchronous active-low reset
//   start      (in)  - one-cycle request to begin a run (ignored while busy)
//   I0, I1, I2 (out) - operand A, operand B and carry-in to the adder
//   sum, carry (in)  - result returned by the adder
//   busy       (out) - high while a run is in progress
//   done       (out) - one-cycle pulse when a run completes
//   pass       (out) - high after a run with no mismatches, held until start
//   err_count  (out) - mismatching vectors in the last run (saturates at 15)
//   fail_vec   (out) - bit k set when vector k mismatched
//
// Build option:
//   FA_CHK_STOP_ON_FAIL_EN - when defined, the first mismatch ends the run
//                            immediately instead of applying every vector.
// -----------------------------------------------------------------------------
module fa_stim_checker
   import fa_chk_pkg::*;
#(
   parameter int DWELL = DWELL_DEFAULT,
   parameter int NVEC  = NVEC_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       I0,
   output logic       I1,
   output logic       I2,
   input  logic       sum,
   input  logic       carry,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_vec
);

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [2:0] LAST_VEC   = 3'(NVEC - 1);

   state_t     state;
   state_t     next_state;
   logic [2:0] vec_idx;
   logic [7:0] dwell_cnt;
   logic [3:0] err_q;
   logic [7:0] fail_q;
   logic       pass_q;
   logic [2:0] operands;
   logic       ref_sum;
   logic       ref_carry;
   logic       mismatch;

   // Golden adder fed with exactly what is being driven to the device.
   fa_ref_model u_ref (
      .a     (operands[2]),
      .b     (operands[1]),
      .cin   (operands[0]),
      .sum   (ref_sum),
      .carry (ref_carry)
   );

   // Only meaningful in SAMPLE; the operands have been stable for DWELL
   // cycles by then, so the adder response has had time to settle.
   assign mismatch = ({carry, sum} != {ref_carry, ref_sum});

   // State register: reset aborts any run without passing through FINISH,
   // so no done pulse can be produced by a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. start is only looked at in IDLE, which is what makes
   // it ignored while a run is in progress.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = DRIVE;
            end
         end
         DRIVE: begin
            if (dwell_cnt == DWELL_LAST) begin
               next_state = SAMPLE;
            end
         end
         SAMPLE: begin
`ifdef FA_CHK_STOP_ON_FAIL_EN
            if (mismatch) begin
               next_state = FINISH;
            end else begin
               next_state = NEXT;
            end
`else
            next_state = NEXT;
`endif
         end
         NEXT: begin
            if (vec_idx == LAST_VEC) begin
               next_state = FINISH;
            end else begin
               next_state = DRIVE;
            end
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output decode. The operands follow the vector index from the first
   // DRIVE cycle through NEXT, so they cannot move between driving and
   // sampling. During FINISH pass is taken straight from the final count
   // so it is valid in the same cycle as done; afterwards the registered
   // copy holds it until the next start.
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == FINISH);
      operands  = 3'b000;
      if (state == DRIVE || state == SAMPLE || state == NEXT) begin
         operands = vec_idx;
      end
      {I0, I1, I2} = operands;
      pass      = (state == FINISH) ? (err_q == 4'd0) : pass_q;
      err_count = err_q;
      fail_vec  = fail_q;
   end

   // Run bookkeeping: dwell timing, vector stepping and result collection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx   <= 3'd0;
         dwell_cnt <= 8'd0;
         err_q     <= 4'd0;
         fail_q    <= 8'd0;
         pass_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec_idx   <= 3'd0;
                  dwell_cnt <= 8'd0;
                  err_q     <= 4'd0;
                  fail_q    <= 8'd0;
                  pass_q    <= 1'b0;
               end
            end
            DRIVE: begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= 8'd0;
               end else begin
                  dwell_cnt <= dwell_cnt + 8'd1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  if (err_q != ERR_MAX) begin
                     err_q <= err_q + 4'd1;
                  end
                  fail_q[vec_idx] <= 1'b1;
               end
            end
            NEXT: begin
               if (vec_idx != LAST_VEC) begin
                  vec_idx <= vec_idx + 3'd1;
               end
            end
            FINISH: begin
               pass_q  <= (err_q == 4'd0);
               vec_idx <= 3'd0;
            end
            default: begin
               vec_idx <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fa_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_fa_stim_checker
// Bench for fa_stim_checker. A behavioural adder (with selectable faults)
// plays the device under test. A run-level model predicts, from run timing
// and adder arithmetic, what busy/done/operands/results must be each cycle.
// A second instance with NVEC=1 covers the single-vector case.
// Honours FA_CHK_STOP_ON_FAIL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fa_stim_checker;

   localparam int D   = 6;
   localparam int N   = 8;
   localparam int PER = D + 2;
   localparam int BOUND = 300;

   // Expected end-of-run values for the faulty-adder runs.
`ifdef FA_CHK_STOP_ON_FAIL_EN
   localparam int         CS_CYC  = 32;
   localparam int         CS_ERR  = 1;
   localparam logic [7:0] CS_FAIL = 8'h08;
   localparam int         SI_CYC  = 8;
   localparam int         SI_ERR  = 1;
   localparam logic [7:0] SI_FAIL = 8'h01;
`else
   localparam int         CS_CYC  = 65;
   localparam int         CS_ERR  = 4;
   localparam logic [7:0] CS_FAIL = 8'hE8;
   localparam int         SI_CYC  = 65;
   localparam int         SI_ERR  = 8;
   localparam logic [7:0] SI_FAIL = 8'hFF;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       i0, i1, i2, sum, carry, busy, done, pass;
   logic [3:0] err_count;
   logic [7:0] fail_vec;
   logic       j0, j1, j2, sum2, carry2, busy2, done2, pass2;
   logic [3:0] err_count2;
   logic [7:0] fail_vec2;

   int fault_mode = 0;
   int tests_run = 0;
   int tests_failed = 0;
   bit chk_en = 1'b0;

   // Run-level model state.
   bit         m_active = 1'b0;
   int         m_r = 0;
   int         m_rfin = 0;
   bit         m_known = 1'b0;
   bit         m_pass = 1'b0;
   int         m_err = 0;
   logic [7:0] m_fail = 8'd0;

   always #5 clk = ~clk;

   fa_stim_checker #(.DWELL(D), .NVEC(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .I0        (i0),
      .I1        (i1),
      .I2        (i2),
      .sum       (sum),
      .carry     (carry),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   fa_stim_checker #(.DWELL(D), .NVEC(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .I0        (j0),
      .I1        (j1),
      .I2        (j2),
      .sum       (sum2),
      .carry     (carry2),
      .busy      (busy2),
      .done      (done2),
      .pass      (pass2),
      .err_count (err_count2),
      .fail_vec  (fail_vec2)
   );

   // Adder arithmetic with fault injection: 0 ideal, 1 carry stuck at 0,
   // 2 sum inverted. Returns {carry,sum}.
   function automatic logic [1:0] adder_resp(input logic [2:0] v, input int mode);
      int   total;
      logic s;
      logic c;
      total = int'(v[2]) + int'(v[1]) + int'(v[0]);
      s = ((total % 2) == 1);
      c = (total >= 2);
      if (mode == 1) c = 1'b0;
      if (mode == 2) s = ~s;
      return {c, s};
   endfunction

   // Behavioural devices under test for both checker instances.
   always_comb begin
      {carry, sum} = adder_resp({i0, i1, i2}, fault_mode);
   end

   always_comb begin
      {carry2, sum2} = adder_resp({j0, j1, j2}, fault_mode);
   end

   // Model of a run: cycle r counts from 1 (first cycle after start is
   // accepted); the results and the finishing cycle are planned up front
   // from the adder arithmetic.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_r      <= 0;
         m_known  <= 1'b1;
         m_pass   <= 1'b0;
         m_err    <= 0;
         m_fail   <= 8'd0;
      end else if (m_active) begin
         if (m_r == m_rfin) begin
            m_active <= 1'b0;
            m_pass   <= (m_err == 0);
         end else begin
            m_r <= m_r + 1;
         end
      end else if (start) begin : plan
         int         err;
         int         rfin;
         bit         stopped;
         logic [7:0] fl;
         err = 0;
         fl = 8'd0;
         stopped = 1'b0;
         rfin = N * PER + 1;
         for (int v = 0; v < N; v++) begin
            if (!stopped && adder_resp(3'(v), fault_mode) != adder_resp(3'(v), 0)) begin
               err++;
               fl[v] = 1'b1;
`ifdef FA_CHK_STOP_ON_FAIL_EN
               stopped = 1'b1;
               rfin = (v + 1) * PER;
`endif
            end
         end
         m_active <= 1'b1;
         m_r      <= 1;
         m_rfin   <= rfin;
         m_err    <= err;
         m_fail   <= fl;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin : cmp
         logic [2:0] eops;
         checkOutput("busy", busy, m_active);
         checkOutput("done", done, m_active && (m_r == m_rfin));
         if (m_active && m_r < m_rfin) begin
            eops = 3'((m_r - 1) / PER);
            checkOutput("operands", {i0, i1, i2}, eops);
            checkOutput("pass_during_run", pass, 1'b0);
         end else if (!m_active) begin
            checkOutput("operands_idle", {i0, i1, i2}, 3'b000);
         end
         if ((m_active && m_r == m_rfin) || (!m_active && m_known)) begin
            checkOutput("pass", pass, m_active ? (m_err == 0) : m_pass);
            checkOutput("err_count", err_count, m_err);
            checkOutput("fail_vec", fail_vec, m_fail);
         end
      end
   end

   // Pulse start on the main instance, optionally re-pulse it mid-run, and
   // count cycles until done plus any extra done pulses afterwards.
   task automatic applyStimulus(input int mode, input bit repulse, output int cycles, output int dones);
      fault_mode = mode;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles = 1;
      dones = 0;
      while (!done && cycles < BOUND) begin
         start = repulse && (cycles == 10 || cycles == 40);
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;
      if (!done) begin
         checkOutput("done_timeout", 32'(cycles), 32'(BOUND + 1));
      end else begin
         dones = 1;
      end
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
   endtask

   initial begin : stim
      int cycles;
      int dones;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_pass", pass, 1'b0);
      checkOutput("rst_err", err_count, 4'd0);
      checkOutput("rst_fail", fail_vec, 8'd0);
      checkOutput("rst_ops", {i0, i1, i2}, 3'b000);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // Ideal adder.
      applyStimulus(0, 1'b0, cycles, dones);
      checkOutput("ideal_latency", cycles, 65);
      checkOutput("ideal_pass", pass, 1'b1);
      checkOutput("ideal_err", err_count, 4'd0);
      checkOutput("ideal_fail", fail_vec, 8'h00);
      checkOutput("ideal_dones", dones, 1);

      // Carry stuck at 0.
      applyStimulus(1, 1'b0, cycles, dones);
      checkOutput("cstuck_latency", cycles, CS_CYC);
      checkOutput("cstuck_pass", pass, 1'b0);
      checkOutput("cstuck_err", err_count, CS_ERR);
      checkOutput("cstuck_fail", fail_vec, CS_FAIL);

      // Sum inverted.
      applyStimulus(2, 1'b0, cycles, dones);
      checkOutput("sinv_latency", cycles, SI_CYC);
      checkOutput("sinv_pass", pass, 1'b0);
      checkOutput("sinv_err", err_count, SI_ERR);
      checkOutput("sinv_fail", fail_vec, SI_FAIL);

      // Start re-pulsed while busy.
      applyStimulus(0, 1'b1, cycles, dones);
      checkOutput("repulse_latency", cycles, 65);
      checkOutput("repulse_dones", dones, 1);
      checkOutput("repulse_pass", pass, 1'b1);

      // Reset in the middle of vector 4.
      fault_mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4 * PER + 2) @(posedge clk);
      #1;
      checkOutput("midrun_ops", {i0, i1, i2}, 3'd4);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_done", done, 1'b0);
      checkOutput("abort_ops", {i0, i1, i2}, 3'b000);
      checkOutput("abort_pass", pass, 1'b0);
      checkOutput("abort_err", err_count, 4'd0);
      checkOutput("abort_fail", fail_vec, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      dones = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      checkOutput("abort_no_done", dones, 0);
      checkOutput("abort_waits", busy, 1'b0);
      applyStimulus(0, 1'b0, cycles, dones);
      checkOutput("after_abort_latency", cycles, 65);
      checkOutput("after_abort_pass", pass, 1'b1);

      // Single-vector instance.
      fault_mode = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      checkOutput("nvec1_busy", busy2, 1'b1);
      checkOutput("nvec1_ops", {j0, j1, j2}, 3'b000);
      cycles = 1;
      while (!done2 && cycles < BOUND) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("nvec1_latency", cycles, 9);
      checkOutput("nvec1_pass", pass2, 1'b1);
      checkOutput("nvec1_err", err_count2, 4'd0);
      checkOutput("nvec1_fail", fail_vec2, 8'd0);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
